fb_pixel_writer: RTL and testbench
==================================

# fb_pixel_writer

Downstream stage of the drawing-engine mux: accepts the selected engine's pixel stream (X, Y, 12-bit color) and writes each pixel into the 160x120 framebuffer RAM write port. It clips off-screen coordinates, buffers bursts in a small FIFO, converts (X, Y) to a linear address, and holds each write until the framebuffer arbiter grants it. The scan-out read port, which has priority, controls the grant.

## Interface
- H_RES, 160, visible columns; X >= H_RES is clipped
- V_RES, 120, visible rows; Y >= V_RES is clipped
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, >= 2)
- ADDR_W, 15, framebuffer address width (covers H_RES*V_RES = 19200)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  upstream pixel present
- pix_ready  out  1  block can accept; transfer occurs when pix_valid & pix_ready at rising clk
- pix_x  in  8  column
- pix_y  in  8  row
- pix_color  in  12  RGB 4:4:4
- fb_we  out  1  write request to framebuffer
- fb_addr  out  ADDR_W  linear address, y*H_RES + x
- fb_data  out  12  pixel color
- fb_grant  in  1  write accepted when fb_we & fb_grant at rising clk
- busy  out  1  FIFO non-empty or write pending
- clip_count  out  16  number of clipped pixels (see Configuration)

## Operation
- Input: pix_ready = !fifo_full. Each accepted pixel is range-checked.
  - Out-of-range pixels (x >= H_RES or y >= V_RES) are consumed but not pushed.
  - In-range pixels are pushed as {x, y, color}.
- FIFO: circular, with write and read pointers one bit wider than the index for full/empty.
  - Simultaneous push and pop is legal at any non-full occupancy.
  - Pushing when full and popping when empty are impossible by construction.
- Address: computed from the FIFO head as (y<<7) + (y<<5) + x for the default H_RES; general form y*H_RES + x.
  - Unsigned arithmetic, truncated to ADDR_W bits; no overflow for in-range inputs.
- Output register FSM, two states:
  - EMPTY: fb_we = 0. If the FIFO is non-empty, pop the head into {fb_addr, fb_data} and go to HOLD.
  - HOLD: fb_we = 1; fb_addr and fb_data are held stable.
    - If fb_grant = 1 and the FIFO is non-empty, pop the next pixel and stay in HOLD (back-to-back, one write per cycle).
    - If fb_grant = 1 and the FIFO is empty, go to EMPTY.
    - If fb_grant = 0, stay in HOLD with no change.
- Writes are issued in acceptance order; no reordering and no merging.
- busy = (FIFO non-empty) | (state == HOLD).

## Timing
- Reset values (asynchronous): state EMPTY, FIFO pointers 0, fb_we 0, fb_addr 0, fb_data 0, busy 0, clip_count 0.
- pix_ready reads 1 during and after reset.
- Latency: pixel accepted at edge N (FIFO empty, state EMPTY) → fb_we = 1 with its address from edge N+1 to N+2.
- Throughput: one pixel per cycle while fb_grant stays high.
- Capacity: FIFO_DEPTH + 1 in-range pixels (FIFO plus output register) can be absorbed under a held-low grant before pix_ready drops.
- pix_ready recovers the cycle after the first pop from a full FIFO.
- Reset asserted mid-operation: pending and buffered writes are discarded; fb_we drops immediately (asynchronous).
- A clipped pixel costs one input cycle and produces no write.

## Configuration
- FB_CLIP_COUNT_EN defined: clip_count increments by 1 on each accepted out-of-range pixel and saturates at 16'hFFFF.
- FB_CLIP_COUNT_EN undefined: the counter logic is omitted and clip_count is tied to 0. Clipping behaviour is otherwise identical.

## Test plan
- Single pixel (3, 2, 12'hF00), fb_grant = 1 → exactly one cycle with fb_we = 1, fb_addr = 323, fb_data = 12'hF00, two edges after acceptance.
- Corner pixels (0, 0) and (159, 119) → fb_addr = 0 and 19199 respectively.
- Clipping: pixels (160, 0) and (0, 120) → no fb_we. clip_count = 2 with FB_CLIP_COUNT_EN, 0 without it.
- Backpressure: fb_grant = 0, pix_valid held high with 7 in-range pixels → 5 accepted, then pix_ready = 0. fb_grant = 1 → 5 writes on consecutive cycles in order; remaining pixels then flow.
- Streaming: 100 consecutive pixels (x = 0..99, y = 5) with fb_grant = 1 → 100 consecutive write cycles, fb_addr = 800..899, pix_ready never deasserts.
- Reset mid-burst: 3 pixels buffered with grant low, then rst_n pulsed low → fb_we = 0, busy = 0, and no stale write after release.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips, buffers and writes a pixel stream into the 160x120 framebuffer write port.
// Define FB_CLIP_COUNT_EN to enable the saturating clip_count; otherwise clip_count is tied to 0.
module fb_pixel_writer #(
  parameter int unsigned H_RES      = 160,
  parameter int unsigned V_RES      = 120,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [7:0]        pix_x,
  input  logic [7:0]        pix_y,
  input  logic [11:0]       pix_color,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [11:0]       fb_data,
  input  logic              fb_grant,
  output logic              busy,
  output logic [15:0]       clip_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t            r_state, w_next;
  logic [27:0]       r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic [ADDR_W-1:0] r_addr;
  logic [11:0]       r_data;
  logic              w_full, w_empty, w_inr, w_acc, w_push, w_pop;
  logic [27:0]       w_head;
  logic [ADDR_W-1:0] w_addr;
  // Entries are packed {x, y, color}.
  assign w_full    = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_empty   = r_wp == r_rp;
  assign pix_ready = !w_full;
  assign w_acc     = pix_valid & pix_ready;
  assign w_inr     = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
  assign w_push    = w_acc & w_inr;
  assign w_pop     = !w_empty && (r_state == EMPTY || fb_grant);
  assign w_head    = r_mem[r_rp[AW-1:0]];
  assign w_addr    = ADDR_W'(32'(w_head[19:12]) * H_RES + 32'(w_head[27:20]));
  assign fb_we     = r_state == HOLD;
  assign fb_addr   = r_addr;
  assign fb_data   = r_data;
  assign busy      = !w_empty | fb_we;
  always_comb begin
    w_next = (r_state == EMPTY) ? (w_empty ? EMPTY : HOLD) : ((fb_grant && w_empty) ? EMPTY : HOLD);
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {pix_x, pix_y, pix_color};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_wp    <= '0;
      r_rp    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_addr <= w_addr;
        r_data <= w_head[11:0];
      end
    end
  end
`ifdef FB_CLIP_COUNT_EN
  logic [15:0] r_clip;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_clip <= '0;
    else if (w_acc && !w_inr && r_clip != 16'hFFFF) r_clip <= r_clip + 16'd1;
  end
  assign clip_count = r_clip;
`else
  assign clip_count = 16'd0;
`endif
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed vector table plus hand-written backpressure, streaming and reset sequences.
module tb_fb_pixel_writer;
  logic        clk = 1'b0, rst_n = 1'b0, pix_valid = 1'b0, fb_grant = 1'b0;
  logic [7:0]  pix_x = '0, pix_y = '0;
  logic [11:0] pix_color = '0;
  logic        pix_ready, fb_we, busy;
  logic [14:0] fb_addr;
  logic [11:0] fb_data;
  logic [15:0] clip_count;
  int checks = 0, failures = 0, cyc = 0, n_acc = 0, n_stall = 0, acc_edge = 0, exp_clip = 0;
  logic [26:0] wq[$];
  int eq[$];

  typedef struct {
    logic [7:0]  x, y;
    logic [11:0] c;
    bit          we;
    logic [14:0] addr;
  } vec_t;
  vec_t v[6];

  fb_pixel_writer dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_grant(fb_grant), .busy(busy),
    .clip_count(clip_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Observe handshakes mid-cycle; each event belongs to the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        n_acc++;
        acc_edge = cyc + 1;
      end
      if (pix_valid && !pix_ready) n_stall++;
      if (fb_we && fb_grant) begin
        wq.push_back({fb_addr, fb_data});
        eq.push_back(cyc + 1);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
    logic a;
    pix_valid = 1'b1; pix_x = x; pix_y = y; pix_color = c;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk) a = pix_ready;
      @(posedge clk);
      #1;
      if (a) return;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: pixel (%0d,%0d) not accepted within 100 cycles", x, y);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [26:0] w;
    v[0] = '{8'd3,   8'd2,   12'hF00, 1'b1, 15'd323};
    v[1] = '{8'd0,   8'd0,   12'h0A5, 1'b1, 15'd0};
    v[2] = '{8'd159, 8'd119, 12'hFFF, 1'b1, 15'd19199};
    v[3] = '{8'd160, 8'd0,   12'h123, 1'b0, 15'd0};
    v[4] = '{8'd0,   8'd120, 12'h456, 1'b0, 15'd0};
    v[5] = '{8'd10,  8'd1,   12'h7E1, 1'b1, 15'd170};

    #12;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(pix_ready), 1);
    chk("rst_clip", 32'(clip_count), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    fb_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wq.delete(); eq.delete();
      send(v[i].x, v[i].y, v[i].c);
      pix_valid = 1'b0;
      idle(4);
      if (!v[i].we) exp_clip++;
      chk($sformatf("vec%0d_writes", i), 32'(wq.size()), 32'(v[i].we));
      if (v[i].we && wq.size() > 0) begin
        w = wq[0];
        chk($sformatf("vec%0d_addr", i), 32'(w[26:12]), 32'(v[i].addr));
        chk($sformatf("vec%0d_data", i), 32'(w[11:0]), 32'(v[i].c));
        chk($sformatf("vec%0d_latency", i), 32'(eq[0] - acc_edge), 2);
      end
      chk($sformatf("vec%0d_busy", i), 32'(busy), 0);
    end
`ifdef FB_CLIP_COUNT_EN
    chk("clip_count", 32'(clip_count), 32'(exp_clip));
`else
    chk("clip_count", 32'(clip_count), 0);
`endif

    wq.delete(); eq.delete();
    fb_grant = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 7; i++) send(8'(20 + i), 8'd3, 12'(i + 1));
        pix_valid = 1'b0;
      end
      begin
        idle(12);
        chk("bp_accepted", 32'(n_acc), 5);
        chk("bp_ready_low", 32'(pix_ready), 0);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_no_write", 32'(wq.size()), 0);
        fb_grant = 1'b1;
      end
    join
    idle(6);
    chk("bp_writes", 32'(wq.size()), 7);
    for (int i = 0; i < 7 && i < wq.size(); i++) begin
      w = wq[i];
      chk($sformatf("bp_addr%0d", i), 32'(w[26:12]), 32'(500 + i));
      chk($sformatf("bp_data%0d", i), 32'(w[11:0]), 32'(i + 1));
    end
    if (eq.size() >= 5) chk("bp_consecutive", 32'(eq[4] - eq[0]), 4);

    wq.delete(); eq.delete();
    n_stall = 0;
    for (int i = 0; i < 100; i++) send(8'(i), 8'd5, 12'(i));
    pix_valid = 1'b0;
    idle(5);
    chk("stream_writes", 32'(wq.size()), 100);
    chk("stream_stalls", 32'(n_stall), 0);
    for (int i = 0; i < 100 && i < wq.size(); i++) begin
      w = wq[i];
      chk($sformatf("stream_addr%0d", i), 32'(w[26:12]), 32'(800 + i));
    end
    if (eq.size() == 100) chk("stream_consecutive", 32'(eq[99] - eq[0]), 99);

    fb_grant = 1'b0;
    for (int i = 0; i < 3; i++) send(8'(i), 8'd1, 12'hABC);
    pix_valid = 1'b0;
    idle(3);
    wq.delete(); eq.delete();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_we", 32'(fb_we), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(fb_we), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(pix_ready), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    fb_grant = 1'b1;
    idle(6);
    chk("arst_no_stale", 32'(wq.size()), 0);
    chk("arst_we_after", 32'(fb_we), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
